fpu_addsub_arbiter: RTL and testbench

Shares the single floating-point add/subtract unit between NUM_REQ requesters (requester 0 = CORDIC FSM, requester 1 = FPU interface main sequencer). Each requester keeps its existing beg/ready/ack handshake. The arbiter latches requests and grants the unit round-robin. It drives the unit's beg/ack handshake and publishes the grant index for the operand and result muxes. One transaction is in flight at a time.

---
 rtl/fpu_addsub_arbiter_pkg.sv | 23 ++
 rtl/fpu_addsub_arbiter_if.sv | 27 ++
 rtl/fpu_addsub_arbiter_rr_pick.sv | 24 ++
 rtl/fpu_addsub_arbiter.sv | 93 +++++++++
 tb/tb_fpu_addsub_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_addsub_arbiter_pkg.sv
// Shared types for the add/subt unit arbiter: FSM state encodings and the
// grant-index width helper.
package fpu_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_DONE    = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  localparam logic [2:0] ST_IDLE    = S_IDLE;
  localparam logic [2:0] ST_START   = S_START;
  localparam logic [2:0] ST_WAIT    = S_WAIT;
  localparam logic [2:0] ST_DONE    = S_DONE;
  localparam logic [2:0] ST_RELEASE = S_RELEASE;

  function automatic int calc_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fpu_addsub_arbiter_if.sv
// Requester and add/subt-unit handshake bundle; slave = arbiter, master = environment.
interface fpu_addsub_arbiter_if import fpu_arb_pkg::*; #(
    parameter int NUM_REQ = 2
);
    localparam int IDX_W = calc_idx_w(NUM_REQ);

    logic [NUM_REQ-1:0] beg_i;
    logic [NUM_REQ-1:0] ack_i;
    logic [NUM_REQ-1:0] ready_o;
    logic               err_o;
    logic               beg_add_subt;
    logic               ready_add_subt;
    logic               ack_add_subt;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               busy;

    modport slave (
        input  beg_i, ack_i, ready_add_subt,
        output ready_o, err_o, beg_add_subt, ack_add_subt, grant_valid, grant_idx, busy
    );

    modport master (
        output beg_i, ack_i, ready_add_subt,
        input  ready_o, err_o, beg_add_subt, ack_add_subt, grant_valid, grant_idx, busy
    );
endinterface

// File: rtl/fpu_addsub_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_pick import fpu_arb_pkg::*; #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = calc_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);
    // Scan from the farthest offset down so the closest requester overwrites last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int k;
            k = (int'(ptr) + i) % NUM_REQ;
            if (req[k]) begin
                found  = 1'b1;
                winner = IDX_W'(k);
            end
        end
    end
endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter sharing one FP add/subt unit among NUM_REQ requesters.
// Optional WAIT-state watchdog: define ARB_WATCHDOG_EN.
module fpu_addsub_arbiter import fpu_arb_pkg::*; #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fpu_addsub_arbiter_if.slave  bus
);
    localparam int IDX_W = calc_idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("fpu_addsub_arbiter: unsupported NUM_REQ/TIMEOUT_CYCLES");
    end

    logic [2:0]         state, state_nxt;
    logic [NUM_REQ-1:0] pending, req, clr_oh, grant_oh;
    logic [IDX_W-1:0]   rr_ptr, gidx, winner;
    logic               found, take, err_q, wd_hit;

    assign req  = pending | bus.beg_i;
    assign take = (state == ST_IDLE) && found;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        clr_oh   = '0;
        grant_oh = '0;
        if (take) clr_oh[winner] = 1'b1;
        grant_oh[gidx] = 1'b1;
    end

`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    // Fires on the last WAIT cycle so DONE lands TIMEOUT_CYCLES after WAIT entry.
    assign wd_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                wd_cnt <= '0;
        else if (state == ST_START)  wd_cnt <= '0;
        else if (state == ST_WAIT)   wd_cnt <= wd_cnt + 1'b1;
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (found) state_nxt = ST_START;
            ST_START:   state_nxt = ST_WAIT;
            ST_WAIT:    if (bus.ready_add_subt || wd_hit) state_nxt = ST_DONE;
            ST_DONE:    if (bus.ack_i[gidx]) state_nxt = ST_RELEASE;
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            pending <= '0;
            rr_ptr  <= '0;
            gidx    <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            // Clear wins over a same-cycle set: the grant consumes that beg.
            pending <= req & ~clr_oh;
            if (take) gidx <= winner;
            if (state == ST_WAIT && (bus.ready_add_subt || wd_hit))
                err_q <= ~bus.ready_add_subt;
            if (state == ST_RELEASE)
                rr_ptr <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        end
    end

    assign bus.beg_add_subt = (state == ST_START);
    assign bus.ack_add_subt = (state == ST_RELEASE);
    assign bus.ready_o      = (state == ST_DONE) ? grant_oh : '0;
    assign bus.err_o        = (state == ST_DONE) && err_q;
    assign bus.grant_valid  = (state != ST_IDLE);
    assign bus.busy         = (state != ST_IDLE);
    assign bus.grant_idx    = gidx;
endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Directed + randomized bench for fpu_addsub_arbiter against a timeline-based model.
module tb_fpu_addsub_arbiter;
  localparam int N  = 2;
  localparam int TO = 8;
`ifdef ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fpu_addsub_arbiter_if #(.NUM_REQ(N)) bus ();

  fpu_addsub_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one transaction described by the cycle numbers of its milestones.
  bit         m_active;
  int         m_owner, m_rr, t_start, done_at, rel_at, cyc;
  bit         m_err;
  bit [N-1:0] m_pend;

  task automatic model_reset();
    m_active = 0; m_owner = 0; m_rr = 0; t_start = -1; done_at = -1; rel_at = -1;
    m_err = 0; m_pend = '0; cyc = 0;
  endtask

  task automatic model_step();
    int c;
    bit [N-1:0] req;
    c = cyc;
    if (!m_active) begin
      req = m_pend | bus.beg_i;
      if (req != 0) begin
        for (int i = 0; i < N; i++) begin
          if (req[(m_rr + i) % N]) begin
            m_owner = (m_rr + i) % N;
            break;
          end
        end
        req[m_owner] = 1'b0;
        m_active = 1; t_start = c + 1; done_at = -1; rel_at = -1; m_err = 0;
      end
      m_pend = req;
    end else begin
      m_pend = m_pend | bus.beg_i;
      if (c > t_start && done_at < 0) begin
        if (bus.ready_add_subt) begin
          done_at = c + 1; m_err = 0;
        end else if (WD && (c - (t_start + 1)) == TO - 1) begin
          done_at = c + 1; m_err = 1;
        end
      end else if (done_at >= 0 && rel_at < 0 && bus.ack_i[m_owner]) begin
        rel_at = c + 1;
      end else if (rel_at >= 0 && c == rel_at) begin
        m_active = 0;
        m_rr = (m_owner + 1) % N;
      end
    end
    cyc = c + 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      bit rd;
      @(negedge clk);
      rd = m_active && done_at >= 0 && cyc >= done_at && rel_at < 0;
      chk("m_beg_add_subt", bus.beg_add_subt, m_active && cyc == t_start);
      chk("m_ack_add_subt", bus.ack_add_subt, m_active && rel_at >= 0 && cyc == rel_at);
      chk("m_ready_o", bus.ready_o, rd ? (32'd1 << m_owner) : 32'd0);
      chk("m_err_o", bus.err_o, rd && m_err);
      chk("m_busy", bus.busy, m_active);
      chk("m_grant_valid", bus.grant_valid, m_active);
      if (m_active) chk("m_grant_idx", bus.grant_idx, m_owner);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic zero_inputs();
    bus.beg_i = '0; bus.ack_i = '0; bus.ready_add_subt = 1'b0;
  endtask

  task automatic do_reset();
    zero_inputs();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  int grants[$];
  bit ub;
  int lat;

  initial begin
    zero_inputs();
    do_reset();
    chk("rst_ready_o", bus.ready_o, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_gv", bus.grant_valid, 0);
    chk("rst_gidx", bus.grant_idx, 0);
    chk("rst_beg", bus.beg_add_subt, 0);
    chk("rst_ack", bus.ack_add_subt, 0);
    chk("rst_err", bus.err_o, 0);

    // Single request, with stray ack_i[1] while 0 owns the unit.
    bus.beg_i = 2'b01;                                   // t
    step(); chk("s1_beg", bus.beg_add_subt, 1); chk("s1_gidx", bus.grant_idx, 0);
    bus.beg_i = 2'b00;
    step(); chk("s1_beg_t2", bus.beg_add_subt, 0);       // t+2
    step(); step(); bus.ready_add_subt = 1'b1;           // t+4
    step(); chk("s1_rdy_t5", bus.ready_o, 2'b01); bus.ack_i = 2'b10;
    step(); chk("s1_rdy_t6", bus.ready_o, 2'b01);
    step(); chk("s1_rdy_t7", bus.ready_o, 2'b01); chk("s1_gidx_t7", bus.grant_idx, 0);
    bus.ack_i = 2'b01;
    step(); chk("s1_ack_t8", bus.ack_add_subt, 1); chk("s1_rdy_t8", bus.ready_o, 0);
    bus.ack_i = 2'b00; bus.ready_add_subt = 1'b0;
    step(); chk("s1_idle_t9", bus.busy, 0);
    // Stray ready in IDLE.
    bus.ready_add_subt = 1'b1;
    repeat (3) begin
      step(); chk("stray_rdy_ready_o", bus.ready_o, 0); chk("stray_rdy_busy", bus.busy, 0);
    end
    bus.ready_add_subt = 1'b0;

    // Simultaneous requests.
    do_reset();
    bus.beg_i = 2'b11;                                   // t
    step(); chk("sim_beg0", bus.beg_add_subt, 1); chk("sim_gidx0", bus.grant_idx, 0);
    bus.beg_i = 2'b00;
    step(); bus.ready_add_subt = 1'b1;                   // t+2
    step(); chk("sim_rdy0", bus.ready_o, 2'b01); bus.ack_i = 2'b01;   // a = t+3
    step(); chk("sim_ack0", bus.ack_add_subt, 1); bus.ack_i = 2'b00; bus.ready_add_subt = 1'b0;
    step(); chk("sim_gap", bus.beg_add_subt, 0);
    step(); chk("sim_beg1", bus.beg_add_subt, 1); chk("sim_gidx1", bus.grant_idx, 1);  // a+3
    step(); bus.ready_add_subt = 1'b1;
    step(); chk("sim_rdy1", bus.ready_o, 2'b10); bus.ack_i = 2'b10;
    step(); chk("sim_ack1", bus.ack_add_subt, 1); zero_inputs();
    step(); chk("sim_idle", bus.busy, 0);

    // Continuous requests from both: strict alternation.
    do_reset();
    grants.delete();
    for (int i = 0; i < 200 && grants.size() < 6; i++) begin
      bus.beg_i = 2'b11; bus.ready_add_subt = 1'b1; bus.ack_i = bus.ready_o;
      step();
      if (bus.beg_add_subt) grants.push_back(int'(bus.grant_idx));
    end
    chk("starve_count", grants.size(), 6);
    for (int i = 0; i < grants.size(); i++) chk("starve_order", grants[i], i % 2);
    zero_inputs();

    // Asynchronous reset during WAIT with requester 1 pending.
    do_reset();
    bus.beg_i = 2'b01;
    step(); bus.beg_i = 2'b10;                           // START
    step(); bus.beg_i = 2'b00;                           // WAIT
    step(); chk("mid_wait_busy", bus.busy, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_gv", bus.grant_valid, 0);
    chk("mid_rst_ready", bus.ready_o, 0);
    chk("mid_rst_beg", bus.beg_add_subt, 0);
    chk("mid_rst_ack", bus.ack_add_subt, 0);
    chk("mid_rst_gidx", bus.grant_idx, 0);
    step();
    reset_n = 1'b1;
    repeat (6) begin step(); chk("mid_post_busy", bus.busy, 0); end

`ifdef ARB_WATCHDOG_EN
    // Watchdog: the unit never answers.
    do_reset();
    bus.beg_i = 2'b01;                                   // t
    step(); bus.beg_i = 2'b00;                           // t+1 START
    repeat (8) step();                                   // t+9
    chk("wd_not_yet", bus.ready_o, 0);
    step();                                              // t+10 = WAIT entry + 8
    chk("wd_ready", bus.ready_o, 2'b01); chk("wd_err", bus.err_o, 1);
    bus.ack_i = 2'b01;
    step(); chk("wd_ack_add", bus.ack_add_subt, 1); chk("wd_err_clr", bus.err_o, 0);
    bus.ack_i = 2'b00;
    step(); chk("wd_idle", bus.busy, 0);
`endif

    // Randomized traffic with a responsive unit and stray signals.
    do_reset();
    ub = 0; lat = 0;
    repeat (3000) begin
      bus.beg_i = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      bus.ack_i = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      if (bus.ack_add_subt) begin
        ub = 0; bus.ready_add_subt = 1'b0;
      end else if (bus.beg_add_subt) begin
        ub = 1; lat = $urandom_range(0, 5); bus.ready_add_subt = 1'b0;
      end else if (ub && !bus.ready_add_subt) begin
        if (lat == 0) bus.ready_add_subt = 1'b1;
        else lat--;
      end else if (!ub) begin
        bus.ready_add_subt = ($urandom_range(0, 7) == 0);
      end
      step();
    end
    zero_inputs();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
